// File: rtl/ecall_pkg.sv
// rtl/ecall_pkg.sv - shared ecall codes, FSM state type and LED indices
package ecall_pkg;

    localparam logic [31:0] ECALL_PRINT_INT = 32'd1;
    localparam logic [31:0] ECALL_READ_INT  = 32'd5;
    localparam logic [31:0] ECALL_EXIT      = 32'd10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_INPUT = 2'd1,
        ST_RESPOND    = 2'd2,
        ST_HALT       = 2'd3
    } state_e;

    localparam int LED_HALT  = 0;
    localparam int LED_PRINT = 2;
    localparam int LED_WAIT  = 7;

endpackage

// File: rtl/ecall_io_ctrl_if.sv
// rtl/ecall_io_ctrl_if.sv - core/board signal bundle for the ecall I/O responder
interface ecall_io_ctrl_if #(
    parameter int SW_WIDTH = 16
);
    logic                ecall_valid;
    logic [31:0]         ecall_code;
    logic [31:0]         a0_in;
    logic [SW_WIDTH-1:0] sw_in;
    logic                confirm_btn;
    logic                stall;
    logic                rd_valid;
    logic [31:0]         rd_data;
    logic [31:0]         disp_value;
    logic                disp_valid;
    logic [7:0]          led_out;
    logic                halted;

    modport master (
        output ecall_valid, ecall_code, a0_in, sw_in, confirm_btn,
        input  stall, rd_valid, rd_data, disp_value, disp_valid, led_out, halted
    );

    modport slave (
        input  ecall_valid, ecall_code, a0_in, sw_in, confirm_btn,
        output stall, rd_valid, rd_data, disp_value, disp_valid, led_out, halted
    );
endinterface

// File: rtl/ecall_io_ctrl_btn_debounce.sv
// rtl/ecall_io_ctrl_btn_debounce.sv - button debouncer with one-cycle press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic btn_db_o,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_db_q, btn_db_d;
    logic          press_q, press_d;

    always_comb begin
        cnt_d    = '0;
        btn_db_d = btn_db_q;
        press_d  = 1'b0;
        if (btn_i != btn_db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = btn_i;
                // the pulse lines up with the cycle btn_db first reads 1
                press_d  = btn_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            btn_db_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            btn_db_q <= btn_db_d;
            press_q  <= press_d;
        end
    end

    assign btn_db_o = btn_db_q;
    assign press_o  = press_q;
endmodule

// File: rtl/ecall_io_ctrl.sv
// rtl/ecall_io_ctrl.sv - ecall print/read/exit responder; SW_SIGN_EXT_EN selects sign-extended reads
module ecall_io_ctrl
    import ecall_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SW_WIDTH        = 16
) (
    input logic            clk,
    input logic            reset,
    ecall_io_ctrl_if.slave bus
);
    state_e      state_q, state_d;
    logic [31:0] rd_data_q, disp_value_q;
    logic        disp_valid_q, led_print_q;
    logic        press, btn_db;
    logic        stall, rd_valid, latch_rd, do_print;
    logic [31:0] sw_ext;
    logic [7:0]  led;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (bus.confirm_btn),
        .btn_db_o (btn_db),
        .press_o  (press)
    );

`ifdef SW_SIGN_EXT_EN
    assign sw_ext = 32'($signed(bus.sw_in));
`else
    assign sw_ext = 32'(bus.sw_in);
`endif

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        rd_valid = 1'b0;
        latch_rd = 1'b0;
        do_print = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ecall_valid) begin
                    if (bus.ecall_code == ECALL_PRINT_INT) begin
                        do_print = 1'b1;
                    end else if (bus.ecall_code == ECALL_READ_INT) begin
                        // stall in the request cycle so the PC cannot advance past the read
                        stall   = 1'b1;
                        state_d = ST_WAIT_INPUT;
                    end else if (bus.ecall_code == ECALL_EXIT) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_WAIT_INPUT: begin
                stall = 1'b1;
                if (press) begin
                    latch_rd = 1'b1;
                    state_d  = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                rd_valid = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_HALT: begin
                stall = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rd_data_q    <= '0;
            disp_value_q <= '0;
            disp_valid_q <= 1'b0;
            led_print_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_rd) begin
                rd_data_q <= sw_ext;
            end
            if (do_print) begin
                disp_value_q <= bus.a0_in;
                disp_valid_q <= 1'b1;
                led_print_q  <= ~led_print_q;
            end
        end
    end

    always_comb begin
        led            = 8'h00;
        led[LED_HALT]  = (state_q == ST_HALT);
        led[LED_PRINT] = led_print_q;
        led[LED_WAIT]  = (state_q == ST_WAIT_INPUT);
    end

    assign bus.stall      = stall;
    assign bus.rd_valid   = rd_valid;
    assign bus.rd_data    = rd_data_q;
    assign bus.disp_value = disp_value_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.led_out    = led;
    assign bus.halted     = (state_q == ST_HALT);

    logic unused_btn_db;
    assign unused_btn_db = btn_db;
endmodule
